// File: rtl/axis_pkt_checker.sv
// Receive-side AXI-Stream packet checker: verifies TUSER length metadata, TKEEP framing and an
// incrementing byte pattern seeded by the packet sequence number; results go to counters and flags.
module axis_pkt_checker #(
    parameter int C_S_AXIS_DATA_WIDTH  = 512,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int MAX_PKT_BYTES        = 9600
) (
    input  logic                               axis_aclk,
    input  logic                               axis_rst,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]   s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]    s_axis_tuser,
    input  logic                               s_axis_tvalid,
    output logic                               s_axis_tready,
    input  logic                               s_axis_tlast,
    input  logic                               enable,
    input  logic                               throttle_en,
    input  logic                               clear,
    output logic                               pkt_done,
    output logic [31:0]                        pkt_count,
    output logic [47:0]                        byte_count,
    output logic [31:0]                        err_count,
    output logic [3:0]                         err_flags,
    output logic [31:0]                        last_err_seq
);

    localparam int          KEEP_W  = C_S_AXIS_DATA_WIDTH / 8;
    localparam int          POP_W   = $clog2(KEEP_W + 1);
    localparam logic [15:0] MAX_LEN = 16'(MAX_PKT_BYTES);

    typedef enum logic {IDLE, IN_PKT} state_t;

    state_t      state, state_nxt;
    logic        phase;
    logic [7:0]  seq;
    logic [7:0]  offset;
    logic [15:0] exp_len;
    logic [15:0] acc_len;
    logic [3:0]  pkt_err;

    logic              beat, pkt_end, first;
    logic [7:0]        beat_offset;
    logic [15:0]       beat_exp_len, prior_len, beat_len;
    logic [3:0]        prior_err, beat_err;
    logic [POP_W-1:0]  keep_pop;
    logic              data_err, keep_err, len_err, oversize;
    logic [16:0]       len_sum;
    logic [KEEP_W-1:0] keep_inc;
    logic [48:0]       byte_sum;
    logic              unused_tuser_hi;

    assign unused_tuser_hi = ^s_axis_tuser[C_S_AXIS_TUSER_WIDTH-1:16];

    assign s_axis_tready = enable & ~axis_rst & (~throttle_en | phase);
    assign beat          = s_axis_tvalid & s_axis_tready;
    assign pkt_end       = beat & s_axis_tlast;
    assign first         = (state == IDLE);

    // A first beat takes its context from seq/tuser directly so back-to-back packets need no bubble.
    assign beat_offset  = first ? seq : offset;
    assign beat_exp_len = first ? s_axis_tuser[15:0] : exp_len;
    assign prior_len    = first ? 16'd0 : acc_len;
    assign prior_err    = first ? 4'd0 : pkt_err;

    always_comb begin : lane_check
        // NOTE: every always_comb output gets a default first, otherwise paths that skip an assignment infer a latch.
        data_err = 1'b0;
        keep_pop = '0;
        for (int k = 0; k < KEEP_W; k++) begin
            if (s_axis_tkeep[k]) begin
                keep_pop = keep_pop + POP_W'(1);
                if (s_axis_tdata[8*k +: 8] != beat_offset + 8'(k)) begin
                    data_err = 1'b1;
                end
            end
        end
    end

    // A contiguous-from-lane-0 mask plus one has no bit in common with the mask itself.
    assign keep_inc = s_axis_tkeep + {{(KEEP_W-1){1'b0}}, 1'b1};
    assign keep_err = s_axis_tlast ? ((s_axis_tkeep == '0) || ((s_axis_tkeep & keep_inc) != '0))
                                   : (s_axis_tkeep != '1);

    assign len_sum  = {1'b0, prior_len} + 17'(keep_pop);
    assign beat_len = len_sum[16] ? 16'hFFFF : len_sum[15:0];
    assign oversize = (beat_len > MAX_LEN);
    assign len_err  = s_axis_tlast && (beat_len != beat_exp_len);
    assign beat_err = prior_err | {oversize, keep_err, data_err, len_err};

    always_comb begin : fsm_next
        state_nxt = state;
        if (beat) begin
            state_nxt = s_axis_tlast ? IDLE : IN_PKT;
        end
    end

    always_ff @(posedge axis_aclk) begin : pkt_state
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (axis_rst) begin
            state   <= IDLE;
            phase   <= 1'b1;
            offset  <= '0;
            exp_len <= '0;
            acc_len <= '0;
            pkt_err <= '0;
        end else begin
            state <= state_nxt;
            phase <= ~phase;
            if (beat) begin
                offset  <= beat_offset + 8'd64;
                exp_len <= beat_exp_len;
                acc_len <= beat_len;
                pkt_err <= beat_err;
            end
        end
    end

    assign byte_sum = {1'b0, byte_count} + 49'(beat_len);

    always_ff @(posedge axis_aclk) begin : stats
        if (axis_rst) begin
            pkt_done     <= 1'b0;
            seq          <= '0;
            pkt_count    <= '0;
            byte_count   <= '0;
            err_count    <= '0;
            err_flags    <= '0;
            last_err_seq <= '0;
        end else begin
            pkt_done <= pkt_end;
            // clear takes priority over a packet completing on the same edge.
            if (clear) begin
                seq          <= '0;
                pkt_count    <= '0;
                byte_count   <= '0;
                err_count    <= '0;
                err_flags    <= '0;
                last_err_seq <= '0;
            end else if (pkt_end) begin
                seq        <= seq + 8'd1;
                byte_count <= byte_sum[48] ? '1 : byte_sum[47:0];
                if (pkt_count != '1) begin
                    pkt_count <= pkt_count + 32'd1;
                end
                if (beat_err != '0) begin
                    err_flags    <= err_flags | beat_err;
                    last_err_seq <= pkt_count;
                    if (err_count != '1) begin
                        err_count <= err_count + 32'd1;
                    end
                end
            end
        end
    end

endmodule
